// File: rtl/pi_control_pkg.sv
// Shared definitions for the PI controller: FSM encoding, default widths and gains,
// and a small width helper used to size intermediate arithmetic.
package pi_control_pkg;

  localparam int DEFAULT_BITWIDTH_MEAN     = 8;
  localparam int DEFAULT_BITWIDTH_OUTPUT   = 8;
  localparam int DEFAULT_BITWIDTH_INTEGRAL = 12;
  localparam int DEFAULT_KP_SHIFT          = 1;
  localparam int DEFAULT_KI_SHIFT          = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ERROR     = 3'd1,
    INTEGRATE = 3'd2,
    SUM       = 3'd3,
    OUTPUT    = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pi_control_saturate.sv
// Signed clamp: limits a value to [lower, upper] and reports whether it had to.
// The result may be narrower than the input; bounds must fit the result width.
module saturate #(
  parameter int in_width  = 13,
  parameter int out_width = 12
) (
  input  logic signed [in_width-1:0]  value,
  input  logic signed [in_width-1:0]  lower,
  input  logic signed [in_width-1:0]  upper,
  output logic        [out_width-1:0] result,
  output logic                        clamped
);

  always_comb begin
    result  = value[out_width-1:0];
    clamped = 1'b0;
    if (value > upper) begin
      result  = upper[out_width-1:0];
      clamped = 1'b1;
    end else if (value < lower) begin
      result  = lower[out_width-1:0];
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/pi_control.sv
// Shift-and-add PI controller: one sample walks IDLE -> ERROR -> INTEGRATE -> SUM -> OUTPUT,
// producing a clamped unsigned control value with fixed latency.
module pi_control
  import pi_control_pkg::*;
#(
  parameter int bitwidth_mean     = DEFAULT_BITWIDTH_MEAN,
  parameter int bitwidth_output   = DEFAULT_BITWIDTH_OUTPUT,
  parameter int bitwidth_integral = DEFAULT_BITWIDTH_INTEGRAL,
  parameter int kp_shift          = DEFAULT_KP_SHIFT,
  parameter int ki_shift          = DEFAULT_KI_SHIFT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic        [bitwidth_mean-1:0]     mean_value,
  input  logic                                mean_valid,
  input  logic        [bitwidth_mean-1:0]     setpoint,
  input  logic                                enable,
  output logic        [bitwidth_output-1:0]   control_value,
  output logic                                control_valid,
  output logic                                busy,
  output logic                                saturated,
  output state_t                              fsm_state,
  output logic signed [bitwidth_integral-1:0] integral,
  output logic                                integral_clamped
);

  localparam int EW = bitwidth_mean + 1;
  localparam int IW = bitwidth_integral;
  localparam int OW = bitwidth_output;
  localparam int AW = max_int(EW, IW) + 1;
  localparam int SW = max_int(EW + kp_shift, IW) + 1;
  localparam int CW = max_int(SW, OW + 1) + 1;

  localparam logic signed [AW-1:0] INT_MAX = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [AW-1:0] INT_MIN = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};
  localparam logic signed [CW-1:0] OUT_MAX = {{(CW-OW){1'b0}}, {OW{1'b1}}};
  localparam logic signed [CW-1:0] OUT_MIN = '0;

  state_t state, next_state;

  logic        [bitwidth_mean-1:0] mean_q, setpoint_q;
  logic signed [EW-1:0]            error_q, error_ki;
  logic signed [SW-1:0]            sum_q, error_ext, integral_ext, sum_next;
  logic signed [AW-1:0]            int_next;
  logic signed [CW-1:0]            sum_wide;
  logic        [IW-1:0]            int_sat;
  logic                            int_sat_flag;
  logic        [OW-1:0]            out_sat;
  logic                            out_sat_flag;

  assign fsm_state = state;
  assign busy      = (state != IDLE);

  // Any state falls back to IDLE as soon as enable goes low.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (mean_valid) next_state = ERROR;
        ERROR:     next_state = INTEGRATE;
        INTEGRATE: next_state = SUM;
        SUM:       next_state = OUTPUT;
        OUTPUT:    next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign error_ki = error_q >>> ki_shift;
  assign int_next = {{(AW-EW){error_ki[EW-1]}}, error_ki}
                  + {{(AW-IW){integral[IW-1]}}, integral};

  assign error_ext    = {{(SW-EW){error_q[EW-1]}}, error_q};
  assign integral_ext = {{(SW-IW){integral[IW-1]}}, integral};
  assign sum_next     = (error_ext <<< kp_shift) + integral_ext;
  assign sum_wide     = {{(CW-SW){sum_q[SW-1]}}, sum_q};

  saturate #(.in_width(AW), .out_width(IW)) u_integral_clamp (
    .value   (int_next),
    .lower   (INT_MIN),
    .upper   (INT_MAX),
    .result  (int_sat),
    .clamped (int_sat_flag)
  );

  saturate #(.in_width(CW), .out_width(OW)) u_output_clamp (
    .value   (sum_wide),
    .lower   (OUT_MIN),
    .upper   (OUT_MAX),
    .result  (out_sat),
    .clamped (out_sat_flag)
  );

  // control_value/saturated only move in OUTPUT, so they hold across disable and aborts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mean_q           <= '0;
      setpoint_q       <= '0;
      error_q          <= '0;
      sum_q            <= '0;
      integral         <= '0;
      integral_clamped <= 1'b0;
      control_value    <= '0;
      saturated        <= 1'b0;
      control_valid    <= 1'b0;
    end else begin
      control_valid <= 1'b0;
      if (!enable) begin
        integral         <= '0;
        integral_clamped <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mean_valid) begin
              mean_q     <= mean_value;
              setpoint_q <= setpoint;
            end
          end
          ERROR:     error_q <= $signed({1'b0, setpoint_q}) - $signed({1'b0, mean_q});
          INTEGRATE: begin
            integral         <= int_sat;
            integral_clamped <= int_sat_flag;
          end
          SUM:       sum_q <= sum_next;
          OUTPUT: begin
            control_value <= out_sat;
            saturated     <= out_sat_flag;
            control_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/pi_control.md
PI_CONTROL -- requirements
Module: pi_control

Interface
REQ-001 Parameter bitwidth_mean, default 8, is the width of the unsigned mean sample and setpoint.
REQ-002 Parameter bitwidth_output, default 8, is the width of the unsigned control output.
REQ-003 Parameter bitwidth_integral, default 12, is the width of the signed integral accumulator.
REQ-004 Parameter kp_shift, default 1, is the proportional gain as a left shift count.
REQ-005 Parameter ki_shift, default 2, is the integral gain as an arithmetic right shift count.
REQ-006 Port clock, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit, is the asynchronous, active-low reset.
REQ-008 Port mean_value, input, bitwidth_mean bits, is the unsigned mean from the averaging stage.
REQ-009 Port mean_valid, input, 1 bit, is a one-cycle strobe marking mean_value as valid.
REQ-010 Port setpoint, input, bitwidth_mean bits, is the unsigned target value.
REQ-011 Port enable, input, 1 bit, runs the controller when high and clears it when low.
REQ-012 Port control_value, output, bitwidth_output bits, is the registered unsigned control result.
REQ-013 Port control_valid, output, 1 bit, is a one-cycle strobe marking a new control_value.
REQ-014 Port busy, output, 1 bit, is high in every state except IDLE.
REQ-015 Port saturated, output, 1 bit, is high when the last control_value was clamped.

Function
REQ-016 The FSM SHALL have the states IDLE, ERROR, INTEGRATE, SUM and OUTPUT, advancing one state per clock.
REQ-017 In IDLE with enable=1 and mean_valid=1, the block SHALL capture mean_value and setpoint and go to ERROR.
REQ-018 ERROR SHALL compute error = setpoint - mean as signed, bitwidth_mean+1 bits.
REQ-019 INTEGRATE SHALL compute integral += (error >>> ki_shift) and clamp the result to the signed range of bitwidth_integral bits.
REQ-020 SUM SHALL compute sum = (error <<< kp_shift) + integral, with width max(bitwidth_mean+1+kp_shift, bitwidth_integral)+1 so nothing is lost.
REQ-021 OUTPUT SHALL clamp sum to [0, 2^bitwidth_output-1], register control_value and saturated, pulse control_valid for exactly one cycle, and return to IDLE.
REQ-022 Latency SHALL be fixed: mean_valid sampled at edge N gives control_valid high in the cycle after edge N+4.
REQ-023 A mean_valid arriving while busy=1 SHALL be ignored, with no queuing.
REQ-024 If enable drops mid-computation, the FSM SHALL abort to IDLE on the next edge, clear the integral, and not assert control_valid.
REQ-025 While enable=0, the integral SHALL stay 0 and control_value and saturated SHALL hold their last values.
REQ-026 mean_valid in the same cycle as the OUTPUT state SHALL be ignored; the FSM accepts a new sample from IDLE only.

Reset
REQ-027 Reset low SHALL immediately force state to IDLE, integral to 0, control_value to 0, and control_valid, busy and saturated to 0.
REQ-028 Reset asserted mid-computation SHALL discard the computation, and no control_valid SHALL follow release.
REQ-029 After reset is released, the first rising edge SHALL be able to accept mean_valid.

Structure
REQ-030 The FSM state encoding and the default gain/width constants SHALL live in the shared package pi_control_pkg.
REQ-031 A single parameterised sub-module, saturate (signed input, min/max bounds, clamped output plus a clamped flag), SHALL be used for both the integral clamp and the output clamp.
REQ-032 All arithmetic SHALL use shifts and adds only, with no multipliers.

Verification
REQ-033 Test: reset released, enable=1, setpoint=100, mean=80, one mean_valid -> control_value=45, saturated=0, control_valid exactly 5 cycles after the strobe.
REQ-034 Test: repeat the same sample a second time -> integral=10, control_value=50.
REQ-035 Test: from reset, setpoint=0, mean=200 -> sum=-450, control_value=0, saturated=1.
REQ-036 Test: setpoint=255, mean=0, 33 samples -> integral clamps at 2047 (not 2079), control_value=255, saturated=1 throughout.
REQ-037 Test: enable dropped in SUM -> no control_valid, integral=0, busy=0 next cycle, and a fresh 100/80 sample again gives 45.
REQ-038 Test: mean_valid strobed on the cycle after acceptance and again while busy -> only one control_valid; reset pulsed in INTEGRATE -> all outputs 0 immediately.
